// File: rtl/parity_pack_pkg.sv
// Shared types and constants for the parity bit packer: FSM state, byte/popcount widths.
package parity_pack_pkg;

  localparam int BYTE_W = 8;
  localparam int ONES_W = 4;
  localparam int IDX_W  = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } pack_state_e;

  function automatic logic [ONES_W-1:0] popcount_byte(input logic [BYTE_W-1:0] b);
    logic [ONES_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      cnt = cnt + ONES_W'(b[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pack_fifo.sv
// Synchronous FIFO for packed bytes; head reads as zero while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module pack_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the head mux below hides stale entries while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/parity_bit_packer.sv
// Packs a serial parity-bit stream into bytes, queues them in pack_fifo, reports popcount.
// Optional macro PACK_DROP_CNT_EN adds a saturating dropped-byte counter output drop_cnt.
module parity_bit_packer
  import parity_pack_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              frame_start,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [ONES_W-1:0] ones_cnt,
  output logic              overflow,
  input  logic              ovf_clr
`ifdef PACK_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  pack_state_e       r_state;
  pack_state_e       w_state_nxt;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [IDX_W-1:0]  w_bit_idx_nxt;
  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] w_shift_nxt;
  logic [BYTE_W-1:0] w_push_data;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic              r_overflow;

  // Maps the arrival index of a bit to its position in the output byte.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx);
    return (MSB_FIRST != 0) ? (IDX_W'(BYTE_W - 1) - idx) : idx;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_push        = 1'b0;
    w_push_data   = '0;
    unique case (r_state)
      IDLE: begin
        if (bit_valid) begin
          w_shift_nxt                   = '0;
          w_shift_nxt[bit_pos(IDX_W'(0))] = bit_in;
          w_bit_idx_nxt                 = IDX_W'(1);
          w_state_nxt                   = COLLECT;
        end
      end
      COLLECT: begin
        if (bit_valid && frame_start) begin
          w_shift_nxt                   = '0;
          w_shift_nxt[bit_pos(IDX_W'(0))] = bit_in;
          w_bit_idx_nxt                 = IDX_W'(1);
        end else if (bit_valid) begin
          w_shift_nxt[bit_pos(r_bit_idx)] = bit_in;
          if (r_bit_idx == IDX_W'(BYTE_W - 1)) begin
            w_push        = 1'b1;
            w_push_data   = w_shift_nxt;
            w_shift_nxt   = '0;
            w_bit_idx_nxt = '0;
            w_state_nxt   = IDLE;
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  pack_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (byte_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (byte_out)
  );

  // A full FIFO is never empty, so byte_ready alone decides whether the head is popped.
  assign w_drop     = w_push && w_full && !byte_ready;
  assign byte_valid = !w_empty;
  assign ones_cnt   = popcount_byte(byte_out);
  assign overflow   = r_overflow;

  always_ff @(posedge clk) begin
    if (rst)          r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

`ifdef PACK_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      r_drop_cnt <= '0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_parity_bit_packer.sv
// Directed bench for parity_bit_packer: LSB-first and MSB-first instances share one stimulus.
module tb_parity_bit_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       frame_start;
  logic       byte_ready;
  logic       ovf_clr;

  logic [7:0] byte_out0, byte_out1;
  logic       byte_valid0, byte_valid1;
  logic [3:0] ones_cnt0, ones_cnt1;
  logic       overflow0, overflow1;
`ifdef PACK_DROP_CNT_EN
  logic [7:0] drop_cnt0, drop_cnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  parity_bit_packer #(.FIFO_DEPTH(4), .MSB_FIRST(0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .byte_out    (byte_out0),
    .byte_valid  (byte_valid0),
    .byte_ready  (byte_ready),
    .ones_cnt    (ones_cnt0),
    .overflow    (overflow0),
    .ovf_clr     (ovf_clr)
`ifdef PACK_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt0)
`endif
  );

  parity_bit_packer #(.FIFO_DEPTH(4), .MSB_FIRST(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .byte_out    (byte_out1),
    .byte_valid  (byte_valid1),
    .byte_ready  (byte_ready),
    .ones_cnt    (ones_cnt1),
    .overflow    (overflow1),
    .ovf_clr     (ovf_clr)
`ifdef PACK_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    bit_in      = b;
    bit_valid   = 1'b1;
    frame_start = fs;
    tick();
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    bit_in      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
  endtask

  task automatic pop_one();
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [4];
    logic [7:0] v;

    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    byte_ready = 1'b0; ovf_clr = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(byte_valid0), 32'h0);
    check("rst_byte",  32'(byte_out0),   32'h0);
    check("rst_ones",  32'(ones_cnt0),   32'h0);
    check("rst_ovf",   32'(overflow0),   32'h0);
`ifdef PACK_DROP_CNT_EN
    check("rst_drop",  32'(drop_cnt0),   32'h0);
`endif
    rst = 1'b0;

    // Stream 1,0,1,1,0,0,0,1: 8'h8D LSB-first, 8'hB1 MSB-first.
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    check("partial_not_valid", 32'(byte_valid0), 32'h0);
    send_bit(1'b1, 1'b0);
    check("lsb_valid", 32'(byte_valid0), 32'h1);
    check("lsb_byte",  32'(byte_out0),   32'h8D);
    check("lsb_ones",  32'(ones_cnt0),   32'h4);
    check("msb_byte",  32'(byte_out1),   32'hB1);
    check("msb_ones",  32'(ones_cnt1),   32'h4);
    tick();
    check("hold_no_ready", 32'(byte_out0), 32'h8D);
    pop_one();
    check("pop_empty", 32'(byte_valid0), 32'h0);

    // Three bits, then a frame restart followed by eight ones.
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    check("restart_valid", 32'(byte_valid0), 32'h1);
    check("restart_byte",  32'(byte_out0),   32'hFF);
    check("restart_ones",  32'(ones_cnt0),   32'h8);
    check("restart_msb",   32'(byte_out1),   32'hFF);
    pop_one();
    check("restart_one_byte", 32'(byte_valid0), 32'h0);

    // frame_start without bit_valid is ignored; idle cycle holds the partial byte.
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    bit_in = 1'b1; frame_start = 1'b1;
    tick();
    bit_in = 1'b0; frame_start = 1'b0;
    check("fs_ignored_valid", 32'(byte_valid0), 32'h0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check("hold_byte_lsb", 32'(byte_out0), 32'hF8);
    check("hold_ones",     32'(ones_cnt0), 32'h5);
    check("hold_byte_msb", 32'(byte_out1), 32'h1F);
    pop_one();

    // Five bytes into a depth-4 FIFO with no consumer: fifth is dropped.
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) send_byte(exp_q[i]);
    check("full_no_ovf", 32'(overflow0), 32'h0);
    send_byte(8'h55);
    check("drop_ovf",      32'(overflow0), 32'h1);
    check("drop_ovf_msb",  32'(overflow1), 32'h1);
    check("drop_head",     32'(byte_out0), 32'h11);
`ifdef PACK_DROP_CNT_EN
    check("drop_cnt",      32'(drop_cnt0), 32'h1);
    check("drop_cnt_msb",  32'(drop_cnt1), 32'h1);
`endif
    byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), 32'(byte_out0), 32'(exp_q[i]));
      tick();
    end
    byte_ready = 1'b0;
    check("drain_empty", 32'(byte_valid0), 32'h0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow0), 32'h0);
`ifdef PACK_DROP_CNT_EN
    check("drop_cleared", 32'(drop_cnt0), 32'h0);
`endif

    // Full FIFO with a pop in the push cycle accepts the new byte.
    for (int i = 0; i < 4; i++) send_byte(8'hA1 + 8'(i));
    v = 8'hA5;
    for (int i = 0; i < 7; i++) send_bit(v[i], 1'b0);
    byte_ready = 1'b1;
    send_bit(v[7], 1'b0);
    byte_ready = 1'b0;
    check("pushpop_no_ovf", 32'(overflow0),   32'h0);
    check("pushpop_head",   32'(byte_out0),   32'hA2);

    // Drop and clear together: the drop wins.
    v = 8'hB6;
    for (int i = 0; i < 7; i++) send_bit(v[i], 1'b0);
    ovf_clr = 1'b1;
    send_bit(v[7], 1'b0);
    ovf_clr = 1'b0;
    check("set_beats_clr", 32'(overflow0), 32'h1);
`ifdef PACK_DROP_CNT_EN
    check("inc_beats_clr", 32'(drop_cnt0), 32'h1);
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared2", 32'(overflow0), 32'h0);
    exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
    byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain2_%0d", i), 32'(byte_out0), 32'(exp_q[i]));
      tick();
    end
    byte_ready = 1'b0;
    check("drain2_empty", 32'(byte_valid0), 32'h0);

    // Reset mid-byte with two queued bytes discards everything.
    send_byte(8'hC1);
    send_byte(8'hC2);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(byte_valid0), 32'h0);
    check("midrst_byte",  32'(byte_out0),   32'h0);
    check("midrst_ones",  32'(ones_cnt0),   32'h0);
    send_byte(8'h5A);
    check("post_rst_valid", 32'(byte_valid0), 32'h1);
    check("post_rst_byte",  32'(byte_out0),   32'h5A);
    check("post_rst_ones",  32'(ones_cnt0),   32'h4);
    pop_one();
    check("post_rst_single", 32'(byte_valid0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
